sg_scan_scheduler: RTL and testbench

Sequencer for the spike-generator state memory. On each TimeMgr unit pulse it scans generator slots 0..num_gens-1, decrements each slot's tick counter, and emits the slot's tag on an output channel when the counter expires. It also arbitrates the single memory port between the scan and host programming writes arriving from PCMapper's SG program channel.

---
 rtl/sg_scan_scheduler_pkg.sv | 24 ++
 rtl/sg_scan_scheduler_slot_update.sv | 21 ++
 rtl/sg_scan_scheduler.sv | 148 ++++++++++++++
 tb/tb_sg_scan_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sg_scan_scheduler_pkg.sv
// Shared spike-generator definitions: slot word layout, scan FSM states and
// the default field widths of the SG state memory.
package sg_scan_scheduler_pkg;

    localparam int N_SG_GENS   = 8;
    localparam int N_SG_PERIOD = 16;
    localparam int N_SG_TAG    = 11;

    typedef struct packed {
        logic [N_SG_PERIOD-1:0] period;
        logic [N_SG_PERIOD-1:0] ticks;
        logic [N_SG_TAG-1:0]    tag;
    } sg_slot_t;

    localparam int SG_SLOT_W = $bits(sg_slot_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_EV,
        ST_EMIT
    } sg_state_t;

endpackage

// File: rtl/sg_scan_scheduler_slot_update.sv
// Per-slot tick evaluation: decides whether a slot fires this time unit and
// what its tick counter becomes.
module sg_slot_update #(
    parameter int PERIOD_W = 16
) (
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [PERIOD_W-1:0] i_ticks,
    output logic                o_enabled,
    output logic                o_emit,
    output logic [PERIOD_W-1:0] o_next_ticks
);

    logic w_expire;

    // ticks of 0 or 1 both reload, so the decrement path never wraps
    assign w_expire     = (i_ticks <= PERIOD_W'(1));
    assign o_enabled    = (i_period != '0);
    assign o_emit       = o_enabled && w_expire;
    assign o_next_ticks = w_expire ? i_period : (i_ticks - PERIOD_W'(1));

endmodule

// File: rtl/sg_scan_scheduler.sv
// Spike-generator scan sequencer: walks the active slots once per time unit,
// updates tick counters, emits expired tags, and shares the memory port with
// host programming writes.
module sg_scan_scheduler
    import sg_scan_scheduler_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_unit_pulse,
    input  logic [N_SG_GENS:0]     i_num_gens,
    input  logic                   i_prog_v,
    output logic                   o_prog_a,
    input  logic [N_SG_GENS-1:0]   i_prog_gen_idx,
    input  logic [N_SG_PERIOD-1:0] i_prog_period,
    input  logic [N_SG_PERIOD-1:0] i_prog_ticks,
    input  logic [N_SG_TAG-1:0]    i_prog_tag,
    output logic [N_SG_GENS-1:0]   o_mem_addr,
    output logic                   o_mem_we,
    output logic [SG_SLOT_W-1:0]   o_mem_wdata,
    input  logic [SG_SLOT_W-1:0]   i_mem_rdata,
    output logic                   o_out_v,
    input  logic                   i_out_a,
    output logic [N_SG_TAG-1:0]    o_out_tag,
    output logic [N_SG_GENS-1:0]   o_out_gen_idx,
    output logic                   o_busy,
    output logic                   o_overrun,
    input  logic                   i_overrun_clr
);

    sg_state_t              r_state;
    logic [N_SG_GENS-1:0]   r_idx;
    logic [N_SG_GENS:0]     r_count;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_out_v;
    logic [N_SG_TAG-1:0]    r_out_tag;
    logic [N_SG_GENS-1:0]   r_out_gen_idx;

    sg_slot_t               w_rd;
    logic                   w_start;
    logic                   w_last;
    logic                   w_en;
    logic                   w_emit;
    logic [N_SG_PERIOD-1:0] w_next_ticks;

    assign w_rd    = i_mem_rdata;
    assign w_start = i_unit_pulse && (i_num_gens != '0);
    assign w_last  = (({1'b0, r_idx} + (N_SG_GENS+1)'(1)) == r_count);

    sg_slot_update #(.PERIOD_W(N_SG_PERIOD)) u_slot_update (
        .i_period     (w_rd.period),
        .i_ticks      (w_rd.ticks),
        .o_enabled    (w_en),
        .o_emit       (w_emit),
        .o_next_ticks (w_next_ticks)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_out_v       <= 1'b0;
            r_out_tag     <= '0;
            r_out_gen_idx <= '0;
        end else begin
            // a pulse landing during a scan is dropped but remembered
            if (i_unit_pulse && r_busy)
                r_overrun <= 1'b1;
            else if (i_overrun_clr)
                r_overrun <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RD;
                        r_idx   <= '0;
                        r_count <= i_num_gens;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RD: r_state <= ST_EV;
                ST_EV: begin
                    if (w_emit) begin
                        r_out_v       <= 1'b1;
                        r_out_tag     <= w_rd.tag;
                        r_out_gen_idx <= r_idx;
                        r_state       <= ST_EMIT;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_RD;
                    end
                end
                ST_EMIT: begin
                    if (i_out_a) begin
                        r_out_v <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_RD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory port: host writes only get the port in IDLE with no scan starting
    always_comb begin
        o_prog_a    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_reset && i_prog_v && !w_start) begin
                    o_prog_a    = 1'b1;
                    o_mem_we    = 1'b1;
                    o_mem_addr  = i_prog_gen_idx;
                    o_mem_wdata = {i_prog_period, i_prog_ticks, i_prog_tag};
                end
            end
            ST_RD:   o_mem_addr = r_idx;
            ST_EV: begin
                o_mem_addr  = r_idx;
                o_mem_we    = w_en;
                o_mem_wdata = {w_rd.period, w_next_ticks, w_rd.tag};
            end
            ST_EMIT: o_mem_addr = r_idx;
            default: o_mem_addr = '0;
        endcase
    end

    assign o_out_v       = r_out_v;
    assign o_out_tag     = r_out_tag;
    assign o_out_gen_idx = r_out_gen_idx;
    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_sg_scan_scheduler.sv
// Scoreboard bench for sg_scan_scheduler: a slot-level reference model predicts
// emitted tags and memory contents; a monitor checks the output channel.
module tb_sg_scan_scheduler;
    import sg_scan_scheduler_pkg::*;

    typedef struct {
        int                  idx;
        logic [N_SG_TAG-1:0] tag;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   up;
    logic [N_SG_GENS:0]     num_gens;
    logic                   prog_v;
    logic                   prog_a;
    logic [N_SG_GENS-1:0]   prog_idx;
    logic [N_SG_PERIOD-1:0] prog_period;
    logic [N_SG_PERIOD-1:0] prog_ticks;
    logic [N_SG_TAG-1:0]    prog_tag;
    logic [N_SG_GENS-1:0]   mem_addr;
    logic                   mem_we;
    logic [SG_SLOT_W-1:0]   mem_wdata;
    logic [SG_SLOT_W-1:0]   mem_rdata;
    logic                   out_v;
    logic                   out_a;
    logic [N_SG_TAG-1:0]    out_tag;
    logic [N_SG_GENS-1:0]   out_idx;
    logic                   busy;
    logic                   overrun;
    logic                   overrun_clr;

    int       n_checks = 0;
    int       errors   = 0;
    int       n_emits  = 0;
    int       a_mode   = 0;
    logic     tb_clear = 1'b1;
    logic     rst_event = 1'b0;
    exp_t     exp_q[$];
    sg_slot_t tbmem [256];
    sg_slot_t ref_mem [256];

    always #5 clk = ~clk;

    sg_scan_scheduler dut (
        .i_clk(clk), .i_reset(rst_n), .i_unit_pulse(up), .i_num_gens(num_gens),
        .i_prog_v(prog_v), .o_prog_a(prog_a), .i_prog_gen_idx(prog_idx),
        .i_prog_period(prog_period), .i_prog_ticks(prog_ticks), .i_prog_tag(prog_tag),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_out_v(out_v), .i_out_a(out_a),
        .o_out_tag(out_tag), .o_out_gen_idx(out_idx), .o_busy(busy),
        .o_overrun(overrun), .i_overrun_clr(overrun_clr)
    );

    // Synchronous-read state memory
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) tbmem[i] <= '0;
        end else begin
            if (mem_we) tbmem[mem_addr] <= mem_wdata;
            mem_rdata <= tbmem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_mem(input string nm);
        int bad = -1;
        for (int i = 0; i < 256; i++)
            if (tbmem[i] !== ref_mem[i]) begin bad = i; break; end
        n_checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: slot %0d got %h expected %h", nm, bad, tbmem[bad], ref_mem[bad]);
        end
    endtask

    // Reference: one time unit applied to slots 0..n-1 as a whole
    function automatic void model_scan(input int n, input bit stop_first);
        for (int i = 0; i < n; i++) begin
            if (ref_mem[i].period == 0) continue;
            if (ref_mem[i].ticks <= 1) begin
                ref_mem[i].ticks = ref_mem[i].period;
                exp_q.push_back('{i, ref_mem[i].tag});
                if (stop_first) return;
            end else begin
                ref_mem[i].ticks = ref_mem[i].ticks - 1;
            end
        end
    endfunction

    // Output acceptance pattern
    initial begin
        out_a = 1'b0;
        forever begin
            @(negedge clk);
            case (a_mode)
                0:       out_a = 1'b1;
                1:       out_a = 1'($urandom_range(0, 1));
                default: out_a = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic                 prev_stall = 1'b0;
        logic [N_SG_TAG-1:0]  prev_tag   = '0;
        logic [N_SG_GENS-1:0] prev_idx   = '0;
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_event) begin
                prev_stall = 1'b0;
                rst_event  = 1'b0;
            end else if (rst_n) begin
                if (prev_stall)
                    chk("stall_hold", {out_v, out_idx, out_tag}, {1'b1, prev_idx, prev_tag});
                if (out_v) begin
                    chk("emit_no_we", mem_we, 0);
                    if (out_a) begin
                        n_emits++;
                        if (exp_q.size() == 0) begin
                            n_checks++; errors++;
                            $display("FAIL emit_unexpected: got idx %0d tag 0x%0h expected none", out_idx, out_tag);
                        end else begin
                            e = exp_q.pop_front();
                            chk("emit", {out_idx, out_tag}, {e.idx[N_SG_GENS-1:0], e.tag});
                        end
                    end
                    prev_stall = !out_a;
                    prev_tag   = out_tag;
                    prev_idx   = out_idx;
                end else begin
                    prev_stall = 1'b0;
                end
                if (prog_a) chk("prog_a_busy", busy, 0);
                if (mem_we && !prog_a) chk("write_disabled", ref_mem[mem_addr].period != 0, 1);
            end
        end
    end

    task automatic do_pulse();
        @(negedge clk);
        up = 1'b1;
        model_scan(int'(num_gens), 1'b0);
        @(negedge clk);
        up = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (!busy) break;
        end
        if (k == 3000) begin
            n_checks++; errors++;
            $display("FAIL %s: busy still 1 expected 0", nm);
        end
    endtask

    task automatic prog(input int idx, input int per, input int tk, input int tg);
        int k;
        sg_slot_t w;
        w = '{N_SG_PERIOD'(per), N_SG_PERIOD'(tk), N_SG_TAG'(tg)};
        @(negedge clk);
        prog_v = 1'b1; prog_idx = N_SG_GENS'(idx);
        prog_period = w.period; prog_ticks = w.ticks; prog_tag = w.tag;
        for (k = 0; k < 500; k++) begin
            #1;
            if (prog_a) break;
            @(negedge clk);
        end
        if (k == 500) begin
            n_checks++; errors++;
            $display("FAIL prog_timeout: prog_a 0 expected 1");
        end else begin
            ref_mem[idx] = w;
        end
        @(negedge clk);
        prog_v = 1'b0;
        #1 chk("prog_word", tbmem[idx], w);
    endtask

    initial begin
        int tk_exp[6] = '{1, 4, 3, 2, 1, 4};
        int lat;
        int k;
        sg_slot_t w;
        rst_n = 1'b0; up = 1'b0; num_gens = '0; prog_v = 1'b0; prog_idx = '0;
        prog_period = '0; prog_ticks = '0; prog_tag = '0; overrun_clr = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_v", out_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_prog_a", prog_a, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr_tag_idx", {mem_addr, out_tag, out_idx}, 0);
        tb_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Slot 3 reload sequence with slot 0 disabled
        prog(0, 0, 0, 'h0AA);
        prog(3, 4, 2, 'h155);
        num_gens = 4;
        a_mode   = 0;
        for (int p = 0; p < 6; p++) begin
            do_pulse();
            wait_idle("scanA");
            chk("slot3_ticks", tbmem[3].ticks, tk_exp[p]);
        end
        chk("emits_A", n_emits, 2);
        cmp_mem("mem_A");

        // Latency from pulse to out_v with slot 0 firing
        prog(0, 3, 1, 'h0F0);
        num_gens = 1;
        do_pulse();
        lat = 0;
        #1;
        while (!out_v && lat < 20) begin @(negedge clk); #1; lat++; end
        chk("latency", lat, 2);
        wait_idle("lat");

        // Backpressure hold, then resume
        prog(5, 2, 1, 'h3C3);
        num_gens = 8;
        a_mode   = 2;
        do_pulse();
        for (k = 0; k < 50; k++) begin @(negedge clk); #1; if (out_v) break; end
        chk("stall_seen", out_v, 1);
        repeat (10) @(negedge clk);
        #1;
        chk("stall_out", {out_v, out_idx, out_tag}, {1'b1, 8'd5, 11'h3C3});
        chk("stall_addr", {mem_we, mem_addr}, {1'b0, 8'd5});
        a_mode = 0;
        wait_idle("stall");
        cmp_mem("mem_stall");

        // Overrun: second pulse two cycles into a scan
        @(negedge clk); up = 1'b1; model_scan(8, 1'b0);
        @(negedge clk); up = 1'b0;
        @(negedge clk); up = 1'b1;
        @(negedge clk); up = 1'b0;
        #1 chk("overrun_set", overrun, 1);
        wait_idle("ovr");
        chk("overrun_sticky", overrun, 1);
        cmp_mem("mem_ovr");
        @(negedge clk); overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        #1 chk("overrun_clr", overrun, 0);

        // Pulse with no active slots is ignored
        num_gens = 0;
        do_pulse();
        #1 chk("zero_gens", {busy, overrun}, 0);
        num_gens = 8;

        // Program request coincident with a pulse waits for the scan
        w = '{16'd5, 16'd3, 11'h123};
        @(negedge clk);
        up = 1'b1; prog_v = 1'b1; prog_idx = 8'd9;
        prog_period = w.period; prog_ticks = w.ticks; prog_tag = w.tag;
        model_scan(8, 1'b0);
        #1 chk("prog_wait", prog_a, 0);
        @(negedge clk); up = 1'b0;
        for (k = 0; k < 500; k++) begin #1; if (prog_a) break; @(negedge clk); end
        chk("prog_after_scan", {k < 500, busy}, {1'b1, 1'b0});
        ref_mem[9] = w;
        @(negedge clk); prog_v = 1'b0;
        #1 chk("prog_coinc_word", tbmem[9], w);
        cmp_mem("mem_coinc");

        // Asynchronous reset in the middle of an emit
        prog(6, 1, 1, 'h611);
        a_mode = 2;
        @(negedge clk); up = 1'b1; model_scan(8, 1'b1);
        @(negedge clk); up = 1'b0;
        for (k = 0; k < 50; k++) begin @(negedge clk); #1; if (out_v) break; end
        #2;
        rst_n = 1'b0; rst_event = 1'b1;
        #1;
        chk("rst_mid_emit", {out_v, busy, mem_we, mem_addr}, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        cmp_mem("mem_rst");
        a_mode = 1;
        do_pulse();
        wait_idle("after_rst");
        cmp_mem("mem_after_rst");

        // Randomized slot programs and scans
        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(0, 3))
                prog($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 2047));
            num_gens = 9'($urandom_range(1, 16));
            do_pulse();
            wait_idle("rand");
            cmp_mem("mem_rand");
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
